// File: rtl/alu_mdu_seq.sv
// Execute unit: single-cycle RV32I ALU ops and iterative multiply/divide behind a
// start/in_ready/done handshake. Result and flags are registered.
//
// state | meaning
// IDLE  | in_ready=1, waiting for start
// CALC  | one shift-add or restoring-divide step per cycle, WIDTH steps
// FIX   | sign correction, special cases, result select
// DONE  | done pulse, Result/flags valid
module alu_mdu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       ALUcontrol,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             in_ready,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic             Z,
  output logic             N,
  output logic             V,
  output logic             C
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int SH_W  = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_SLT   = 4'b0101;
  localparam logic [3:0] OP_SLTU  = 4'b0110;
  localparam logic [3:0] OP_SLL   = 4'b0111;
  localparam logic [3:0] OP_SRL   = 4'b1000;
  localparam logic [3:0] OP_SRA   = 4'b1001;
  localparam logic [3:0] OP_MUL   = 4'b1010;
  localparam logic [3:0] OP_MULHU = 4'b1011;
  localparam logic [3:0] OP_DIVU  = 4'b1100;
  localparam logic [3:0] OP_REMU  = 4'b1101;
  localparam logic [3:0] OP_DIV   = 4'b1110;
  localparam logic [3:0] OP_REM   = 4'b1111;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   a_orig;
  logic [3:0]         op_q;
  logic               sign_a;
  logic               sign_b;

  // single-cycle ALU path
  logic [WIDTH:0]    add_sum;
  logic [WIDTH:0]    sub_diff;
  logic [SH_W-1:0]   shamt;
  logic [WIDTH-1:0]  alu_res;
  logic              alu_v;
  logic              alu_c;

  assign add_sum  = {1'b0, A} + {1'b0, B};
  assign sub_diff = {1'b0, A} + {1'b0, ~B} + (WIDTH+1)'(1);
  assign shamt    = B[SH_W-1:0];

  always_comb begin
    alu_res = '0;
    alu_v   = 1'b0;
    alu_c   = 1'b0;
    case (ALUcontrol)
      OP_ADD: begin
        alu_res = add_sum[WIDTH-1:0];
        alu_c   = add_sum[WIDTH];
        alu_v   = (A[WIDTH-1] == B[WIDTH-1]) && (add_sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_diff[WIDTH-1:0];
        alu_c   = sub_diff[WIDTH];
        alu_v   = (A[WIDTH-1] != B[WIDTH-1]) && (sub_diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND:  alu_res = A & B;
      OP_OR:   alu_res = A | B;
      OP_XOR:  alu_res = A ^ B;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (A < B)};
      OP_SLL:  alu_res = A << shamt;
      OP_SRL:  alu_res = A >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(A) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  // operand capture for the iterative path: divides work on magnitudes
  logic             in_sdiv;
  logic             in_mul;
  logic             in_sa;
  logic             in_sb;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  assign in_mul  = (ALUcontrol[3:1] == 3'b101);
  assign in_sdiv = (ALUcontrol[3:1] == 3'b111);
  assign in_sa   = in_sdiv & A[WIDTH-1];
  assign in_sb   = in_sdiv & B[WIDTH-1];
  assign a_mag   = in_sa ? (~A + ONE) : A;
  assign b_mag   = in_sb ? (~B + ONE) : B;

  // one iteration step; acc holds {product high, multiplier} or {remainder, quotient}
  logic             is_mul_q;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_sub;
  logic [2*WIDTH-1:0] acc_next;

  assign is_mul_q  = (op_q[3:1] == 3'b101);
  assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
  assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, opnd});
  assign div_sub   = WIDTH'(div_shift - {1'b0, opnd});

  always_comb begin
    acc_next = acc;
    if (is_mul_q)
      acc_next = {mul_sum, acc[WIDTH-1:1]};
    else if (div_ge)
      acc_next = {div_sub, acc[WIDTH-2:0], 1'b1};
    else
      acc_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
  end

  // result select; divide-by-zero follows RISC-V rather than the raw restoring output
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic             b_zero;
  logic [WIDTH-1:0] fix_res;

  assign quo    = acc[WIDTH-1:0];
  assign rem    = acc[2*WIDTH-1:WIDTH];
  assign b_zero = (opnd == '0);

  always_comb begin
    fix_res = quo;
    case (op_q)
      OP_MUL:   fix_res = quo;
      OP_MULHU: fix_res = rem;
      OP_DIVU:  fix_res = b_zero ? '1 : quo;
      OP_REMU:  fix_res = b_zero ? a_orig : rem;
      OP_DIV:   fix_res = b_zero ? '1 : ((sign_a ^ sign_b) ? (~quo + ONE) : quo);
      OP_REM:   fix_res = b_zero ? a_orig : (sign_a ? (~rem + ONE) : rem);
      default:  fix_res = quo;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      a_orig   <= '0;
      op_q     <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      Result   <= '0;
      Z        <= 1'b0;
      N        <= 1'b0;
      V        <= 1'b0;
      C        <= 1'b0;
      done     <= 1'b0;
      in_ready <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            in_ready <= 1'b0;
            if (ALUcontrol < OP_MUL) begin
              Result <= alu_res;
              Z      <= (alu_res == '0);
              N      <= alu_res[WIDTH-1];
              V      <= alu_v;
              C      <= alu_c;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              op_q   <= ALUcontrol;
              a_orig <= A;
              sign_a <= in_sa;
              sign_b <= in_sb;
              cnt    <= CNT_W'(WIDTH);
              if (in_mul) begin
                acc  <= {{WIDTH{1'b0}}, B};
                opnd <= A;
              end else begin
                acc  <= {{WIDTH{1'b0}}, a_mag};
                opnd <= b_mag;
              end
              state <= CALC;
            end
          end
        end
        CALC: begin
          acc <= acc_next;
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1))
            state <= FIX;
        end
        FIX: begin
          Result <= fix_res;
          Z      <= (fix_res == '0);
          N      <= fix_res[WIDTH-1];
          V      <= 1'b0;
          C      <= 1'b0;
          done   <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          in_ready <= 1'b1;
          state    <= IDLE;
        end
        default: begin
          in_ready <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mdu_seq.sv
// Self-checking bench for alu_mdu_seq: table of vectors through a scoreboard on a
// 32-bit instance, plus hand sequences for ignored starts, abort and a 16-bit instance.
module tb_alu_mdu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        in_ready, done;
  logic [31:0] result;
  logic        z, n, v, c;

  logic        rst16;
  logic        start16;
  logic [3:0]  op16;
  logic [15:0] a16, b16;
  logic        in_ready16, done16;
  logic [15:0] result16;
  logic        z16, n16, v16, c16;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_mdu_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .ALUcontrol(op), .A(a), .B(b),
    .in_ready(in_ready), .done(done), .Result(result),
    .Z(z), .N(n), .V(v), .C(c)
  );

  alu_mdu_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst16), .start(start16), .ALUcontrol(op16), .A(a16), .B(b16),
    .in_ready(in_ready16), .done(done16), .Result(result16),
    .Z(z16), .N(n16), .V(v16), .C(c16)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  f;   // {Z,N,V,C}
    int          lat;
  } vec_t;

  typedef struct {
    int          id;
    logic [31:0] res;
    logic [3:0]  f;
    int          cyc;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic add(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] r, input logic [3:0] f, input int lat);
    vec_t t;
    t.op = o; t.a = x; t.b = y; t.res = r; t.f = f; t.lat = lat;
    vecs.push_back(t);
  endtask

  // done of cycle n (accept edge = cycle 0) is sampled at the negedge where cyc == accept+n-1
  task automatic issue(input int id, input logic [3:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] r, input logic [3:0] f,
                       input int lat, output int acc);
    int   w;
    exp_t e;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL ready_timeout[%0d]: in_ready still %b after %0d cycles", id, in_ready, w);
    end
    e.id = id; e.res = r; e.f = f; e.cyc = cyc + lat;
    sb.push_back(e);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    acc = cyc;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL spurious_done: done=1 at cyc %0d with nothing outstanding", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk($sformatf("result[%0d]", e.id), result, e.res);
          chk($sformatf("flags[%0d]", e.id), {28'b0, z, n, v, c}, {28'b0, e.f});
          chk($sformatf("latency[%0d]", e.id), cyc, e.cyc);
        end
      end else if (sb.size() > 0 && cyc > sb[0].cyc) begin
        total++; bad++;
        $display("FAIL late_done[%0d]: no done by cyc %0d, wanted at %0d", sb[0].id, cyc, sb[0].cyc);
        void'(sb.pop_front());
      end
    end
  end

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() > 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (sb.size() > 0) begin
      total++; bad++;
      $display("FAIL drain: %0d results outstanding, want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic run16(input string name, input logic [3:0] o, input logic [15:0] x,
                       input logic [15:0] y, input logic [15:0] r, input logic [3:0] f);
    int done_at, notready;
    done_at = -1;
    notready = 0;
    @(negedge clk);
    start16 = 1'b1; op16 = o; a16 = x; b16 = y;
    @(negedge clk);
    start16 = 1'b0;
    a16 = 16'($urandom);
    b16 = 16'($urandom);
    for (int k = 1; k <= 40 && done_at < 0; k++) begin
      if (done16) begin
        done_at = k;
        chk({name, "_result"}, {16'b0, result16}, {16'b0, r});
        chk({name, "_flags"}, {28'b0, z16, n16, v16, c16}, {28'b0, f});
      end else if (!in_ready16) begin
        notready++;
      end
      @(negedge clk);
    end
    chk({name, "_done_cycle"}, done_at, 18);
    chk({name, "_notready"}, notready, 17);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc, notready;

    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    rst16 = 1'b1; start16 = 1'b0; op16 = '0; a16 = '0; b16 = '0;

    add(4'h0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b0110, 1);
    add(4'h1, 32'h00000005, 32'h00000005, 32'h00000000, 4'b1001, 1);
    add(4'h5, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 4'b0000, 1);
    add(4'h6, 32'h80000000, 32'h7FFFFFFF, 32'h00000000, 4'b1000, 1);
    add(4'h2, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 4'b0000, 1);
    add(4'h3, 32'hF0000000, 32'h0000000F, 32'hF000000F, 4'b0100, 1);
    add(4'h4, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h00000000, 4'b1000, 1);
    add(4'h7, 32'h00000003, 32'h00000021, 32'h00000006, 4'b0000, 1);
    add(4'h8, 32'h80000000, 32'h00000004, 32'h08000000, 4'b0000, 1);
    add(4'h9, 32'h80000000, 32'h00000004, 32'hF8000000, 4'b0100, 1);
    add(4'h1, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 4'b0100, 1);
    add(4'h0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1001, 1);
    add(4'h1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0011, 1);
    add(4'hA, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 4'b0000, 34);
    add(4'hB, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 4'b0100, 34);
    add(4'hA, 32'h12345678, 32'h00000010, 32'h23456780, 4'b0000, 34);
    add(4'hB, 32'h80000000, 32'h00000004, 32'h00000002, 4'b0000, 34);
    add(4'hE, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 4'b0100, 34);
    add(4'hF, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 4'b0100, 34);
    add(4'hE, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 4'b0100, 34);
    add(4'hF, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 4'b1000, 34);
    add(4'hC, 32'h00000007, 32'h00000000, 32'hFFFFFFFF, 4'b0100, 34);
    add(4'hD, 32'h00000007, 32'h00000000, 32'h00000007, 4'b0000, 34);
    add(4'hE, 32'h00000007, 32'h00000000, 32'hFFFFFFFF, 4'b0100, 34);
    add(4'hF, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 4'b0100, 34);
    add(4'hC, 32'h00000064, 32'h00000007, 32'h0000000E, 4'b0000, 34);
    add(4'hD, 32'h00000064, 32'h00000007, 32'h00000002, 4'b0000, 34);
    add(4'hE, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 4'b0100, 34);
    add(4'hF, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 4'b0000, 34);

    #2;
    chk("reset_result", result, 32'h0);
    chk("reset_flags", {28'b0, z, n, v, c}, 32'h0);
    chk("reset_done", {31'b0, done}, 32'h0);
    chk("reset_in_ready", {31'b0, in_ready}, 32'h1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    rst16 = 1'b0;

    foreach (vecs[i])
      issue(i, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].f, vecs[i].lat, acc);
    drain();

    // starts hammered while a multiply is in flight must be dropped
    issue(100, 4'hA, 32'h00010003, 32'h00000005, 32'h0005000F, 4'b0000, 34, acc);
    notready = 0;
    for (int k = 1; k <= 33; k++) begin
      if (!in_ready) notready++;
      start = (k < 33);
      op = 4'h0; a = 32'h1; b = 32'h1;
      @(negedge clk);
    end
    start = 1'b0;
    chk("busy_notready", notready, 33);
    drain();

    // reset in the middle of a divide
    issue(200, 4'hC, 32'hFFFFFFFF, 32'h00000003, 32'h55555555, 4'b0000, 34, acc);
    while (cyc < acc + 9) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    #1;
    chk("abort_result", result, 32'h0);
    chk("abort_flags", {28'b0, z, n, v, c}, 32'h0);
    chk("abort_in_ready", {31'b0, in_ready}, 32'h1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_ready_after", {31'b0, in_ready}, 32'h1);
    repeat (40) @(negedge clk);
    issue(201, 4'h0, 32'h00000002, 32'h00000003, 32'h00000005, 4'b0000, 1, acc);
    drain();

    run16("w16_mul", 4'hA, 16'hFFFF, 16'hFFFF, 16'h0001, 4'b0000);
    run16("w16_mulhu", 4'hB, 16'hFFFF, 16'hFFFF, 16'hFFFE, 4'b0100);

    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
